// File: rtl/traffic_light_pkg.sv
// Shared light encodings and override FSM state constants for the traffic-light manual path.
// Pure definitions: no timing or flow control.
package traffic_light_pkg;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

  typedef logic [1:0] ovr_state_t;

  localparam ovr_state_t ST_IDLE   = 2'd0;
  localparam ovr_state_t ST_RED    = 2'd1;
  localparam ovr_state_t ST_GREEN  = 2'd2;
  localparam ovr_state_t ST_YELLOW = 2'd3;

  function automatic logic [1:0] state_light(input ovr_state_t s);
    case (s)
      ST_GREEN:  return LIGHT_GREEN;
      ST_YELLOW: return LIGHT_YELLOW;
      default:   return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop sync -> debounce counter -> one-cycle rising-edge pulse.
// Latency: pulse 2+DEBOUNCE_CYCLES cycles after first sample; no backpressure.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Any sample agreeing with the current level restarts the run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/manual_override_driver.sv
// Operator buttons -> manual_override/manual_state; green always exits via YELLOW_HOLD cycles of yellow.
// Outputs registered one edge after a press pulse; OVERRIDE_TIMEOUT_EN adds idle auto-release.
module manual_override_driver
  import traffic_light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_HOLD        = 2,
  parameter int unsigned YELLOW_HOLD     = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_take,
  input  logic       btn_next,
  input  logic       btn_release,
  output logic       manual_override,
  output logic [1:0] manual_state,
  output logic       busy
);

  localparam int unsigned HW = $clog2(MIN_HOLD + 1);
  localparam int unsigned YW = $clog2(YELLOW_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  localparam logic [YW-1:0] YEL_LAST = YW'(YELLOW_HOLD - 1);

  logic          w_take;
  logic          w_next;
  logic          w_rel;
  logic          w_timeout;
  ovr_state_t    r_state;
  ovr_state_t    w_nxt_state;
  logic          r_pend;
  logic          w_nxt_pend;
  logic [HW-1:0] r_hold;
  logic [YW-1:0] r_ycnt;
  logic          r_override;
  logic [1:0]    r_light;
  logic          r_busy;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_take (
    .clk(clk), .reset(reset), .i_btn(btn_take), .o_pulse(w_take)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(clk), .reset(reset), .i_btn(btn_next), .o_pulse(w_next)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rel (
    .clk(clk), .reset(reset), .i_btn(btn_release), .o_pulse(w_rel)
  );

`ifdef OVERRIDE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_idle;

  // Every accepted press changes state, so clearing on entry covers both cases.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= '0;
    end else if (w_nxt_state != r_state) begin
      r_idle <= '0;
    end else if (r_state == ST_RED || r_state == ST_GREEN) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_RED || r_state == ST_GREEN) && (r_idle == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pend  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_take) w_nxt_state = ST_RED;
      end
      ST_RED: begin
        if (w_rel || w_timeout)              w_nxt_state = ST_IDLE;
        else if (w_next && r_hold >= HOLD_MAX) w_nxt_state = ST_GREEN;
      end
      ST_GREEN: begin
        if (w_rel || w_timeout) begin
          w_nxt_state = ST_YELLOW;
          w_nxt_pend  = 1'b1;
        end else if (w_next && r_hold >= HOLD_MAX) begin
          w_nxt_state = ST_YELLOW;
        end
      end
      default: begin
        if (w_rel) w_nxt_pend = 1'b1;
        // A release landing in the final yellow cycle still counts.
        if (r_ycnt == YEL_LAST) begin
          w_nxt_state = (r_pend || w_rel) ? ST_IDLE : ST_RED;
          w_nxt_pend  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pend     <= 1'b0;
      r_hold     <= '0;
      r_ycnt     <= '0;
      r_override <= 1'b0;
      r_light    <= LIGHT_RED;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pend  <= w_nxt_pend;
      if (w_nxt_state != r_state)  r_hold <= '0;
      else if (r_hold < HOLD_MAX)  r_hold <= r_hold + 1'b1;
      if (w_nxt_state != r_state)  r_ycnt <= '0;
      else if (r_state == ST_YELLOW) r_ycnt <= r_ycnt + 1'b1;
      r_override <= (w_nxt_state != ST_IDLE);
      r_light    <= state_light(w_nxt_state);
      r_busy     <= (w_nxt_state == ST_YELLOW);
    end
  end

  assign manual_override = r_override;
  assign manual_state    = r_light;
  assign busy            = r_busy;

endmodule

// File: tb/tb_manual_override_driver.sv
// Bench for manual_override_driver: directed scenarios with literal expectations,
// then randomized buttons/resets against a cycle-level behavioural model.
module tb_manual_override_driver;

  localparam int DB = 4;
  localparam int MH = 2;
  localparam int YH = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_take = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_release = 1'b0;
  logic       manual_override;
  logic [1:0] manual_state;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  manual_override_driver #(
    .DEBOUNCE_CYCLES(DB), .MIN_HOLD(MH), .YELLOW_HOLD(YH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .btn_take(btn_take), .btn_next(btn_next),
    .btn_release(btn_release), .manual_override(manual_override),
    .manual_state(manual_state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0 idle, 1 red, 2 green, 3 yellow; tin = edges spent in mode so far.
  int        m_mode = 0;
  int        m_tin = 0;
  bit        m_pend = 1'b0;
  bit [15:0] m_hist [3];
  bit        m_lvl [3];
  bit        m_pul [3];
  bit        m_started = 1'b0;
  int        rst_edges = 0;

  always @(posedge clk) begin : model
    bit raw [3];
    bit all_flip;
    int nm;
    bit np;
    bit to;
    raw[0] = btn_take;
    raw[1] = btn_next;
    raw[2] = btn_release;
    m_started = 1'b1;
    if (reset) begin
      m_mode = 0; m_tin = 0; m_pend = 1'b0; rst_edges++;
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0; m_lvl[b] = 1'b0; m_pul[b] = 1'b0;
      end
    end else begin
      nm = m_mode;
      np = m_pend;
`ifdef OVERRIDE_TIMEOUT_EN
      to = (m_mode == 1 || m_mode == 2) && (m_tin == TO - 1);
`else
      to = 1'b0;
`endif
      if (m_mode == 0) begin
        if (m_pul[0]) nm = 1;
      end else if (m_mode == 1) begin
        if (m_pul[2] || to) nm = 0;
        else if (m_pul[1] && m_tin >= MH) nm = 2;
      end else if (m_mode == 2) begin
        if (m_pul[2] || to) begin nm = 3; np = 1'b1; end
        else if (m_pul[1] && m_tin >= MH) nm = 3;
      end else begin
        if (m_pul[2]) np = 1'b1;
        if (m_tin == YH - 1) begin
          nm = (m_pend || m_pul[2]) ? 0 : 1;
          np = 1'b0;
        end
      end
      m_tin  = (nm != m_mode) ? 0 : m_tin + 1;
      m_mode = nm;
      m_pend = np;
      // A debounced level flips once DB consecutive synchronized samples disagree with it.
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = {m_hist[b][14:0], raw[b]};
        all_flip = 1'b1;
        for (int k = 2; k < 2 + DB; k++)
          if (m_hist[b][k] == m_lvl[b]) all_flip = 1'b0;
        m_pul[b] = all_flip && !m_lvl[b];
        if (all_flip) m_lvl[b] = !m_lvl[b];
      end
    end
  end

  int busy_run = 0;
  int run_rst  = 0;

  always @(negedge clk) begin : compare
    int exp_v;
    int act_v;
    if (m_started) begin
      exp_v = {(m_mode != 0), (m_mode == 2) ? 2'b10 : (m_mode == 3) ? 2'b01 : 2'b00, (m_mode == 3)};
      act_v = {manual_override, manual_state, busy};
      chk("model {override,state,busy}", act_v, exp_v);
      if (busy === 1'b1) begin
        if (busy_run == 0) run_rst = rst_edges;
        busy_run++;
      end else begin
        if (busy_run > 0 && run_rst == rst_edges) chk("yellow run length", busy_run, YH);
        busy_run = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next();
    btn_next = 1'b1; cyc(7); btn_next = 1'b0; cyc(10);
  endtask

  initial begin : stim
    bit saw_green;
    int rem [3];
    bit val [3];

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset override", manual_override, 0);
      chk("reset state", manual_state, 0);
      chk("reset busy", busy, 0);
    end
    reset = 1'b0;
    cyc(2);

    btn_take = 1'b1; cyc(2); btn_take = 1'b0; cyc(12);
    chk("glitch ignored", manual_override, 0);

    btn_take = 1'b1; cyc(6);
    chk("take before pulse", manual_override, 0);
    cyc(1);
    chk("take override", manual_override, 1);
    chk("take red", manual_state, 0);
    cyc(3); btn_take = 1'b0; cyc(10);

    press_next();
    chk("next to green", manual_state, 2);
    btn_next = 1'b1; cyc(7);
    chk("yellow state c1", manual_state, 1);
    chk("yellow busy c1", busy, 1);
    cyc(2);
    chk("yellow state c3", manual_state, 1);
    cyc(1);
    chk("after yellow red", manual_state, 0);
    chk("after yellow busy", busy, 0);
    chk("after yellow override", manual_override, 1);
    btn_next = 1'b0; cyc(10);

    press_next();
    chk("green again", manual_state, 2);
    btn_release = 1'b1; cyc(7);
    chk("release yellow", manual_state, 1);
    cyc(2);
    chk("release yellow c3", busy, 1);
    cyc(1);
    chk("release to idle", manual_override, 0);
    chk("release idle state", manual_state, 0);
    btn_release = 1'b0; cyc(10);

    btn_take = 1'b1; cyc(7); btn_take = 1'b0; cyc(10);
    chk("red for simul", manual_override, 1);
    saw_green = 1'b0;
    btn_next = 1'b1; btn_release = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (manual_state == 2'b10) saw_green = 1'b1;
      if (i == 7) begin btn_next = 1'b0; btn_release = 1'b0; end
    end
    chk("simul never green", saw_green, 0);
    chk("simul release wins", manual_override, 0);

    // Take and next one cycle apart: next lands one cycle into RED, before MIN_HOLD.
    btn_take = 1'b1; cyc(1); btn_next = 1'b1; cyc(6);
    chk("early take red", manual_override, 1);
    cyc(1);
    chk("early next dropped", manual_state, 0);
    cyc(3); btn_take = 1'b0; btn_next = 1'b0; cyc(10);
    chk("early next not queued", manual_state, 0);
    press_next();
    chk("late next accepted", manual_state, 2);

    btn_next = 1'b1; cyc(7);
    chk("yellow before reset", busy, 1);
    reset = 1'b1; cyc(1);
    chk("reset in yellow override", manual_override, 0);
    chk("reset in yellow state", manual_state, 0);
    chk("reset in yellow busy", busy, 0);
    reset = 1'b0; btn_next = 1'b0; cyc(10);

`ifdef OVERRIDE_TIMEOUT_EN
    btn_take = 1'b1; cyc(7); btn_take = 1'b0;
    chk("timeout red entered", manual_override, 1);
    cyc(15);
    chk("timeout not yet", manual_override, 1);
    cyc(1);
    chk("timeout released", manual_override, 0);
    cyc(10);
`endif

    for (int b = 0; b < 3; b++) begin rem[b] = 0; val[b] = 1'b0; end
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          val[b] = !val[b];
          rem[b] = $urandom_range(1, 16);
        end
        rem[b]--;
      end
      btn_take    = val[0];
      btn_next    = val[1];
      btn_release = (c % 400 < 200) ? 1'b0 : val[2];
      reset       = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
